// File: rtl/bird_pkg.sv
// bird_pkg: shared bird life-cycle states, screen geometry and default physics constants.
package bird_pkg;
  typedef enum logic [1:0] {IDLE, FLY, DEAD} bird_state_t;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_ROWS = 480;
  localparam int DEF_N = 10;
  localparam int DEF_BIRD_SIZE = 15;
  localparam int DEF_START_X = 160;
  localparam int DEF_START_Y = 240;
  localparam int DEF_TICK_DIV = 2097152;
  localparam int DEF_GRAVITY = 1;
  localparam int DEF_FLAP_VEL = 8;
  localparam int DEF_VMAX = 12;
  localparam int DEF_VW = 6;
endpackage

// File: rtl/bird_physics_if.sv
// bird_physics_if: game-side controls into the bird and its bounding box / status out.
interface bird_physics_if #(parameter int N = 10, parameter int VW = 6);
  logic start, flap, hit;
  logic [N-1:0] x0, x1, y0, y1;
  logic signed [VW-1:0] vel;
  logic [1:0] state;
  logic tick;
  modport master(output start, flap, hit, input x0, x1, y0, y1, vel, state, tick);
  modport slave(input start, flap, hit, output x0, x1, y0, y1, vel, state, tick);
endinterface

// File: rtl/bird_tick_gen.sv
// bird_tick_gen: physics tick strobe, one cycle in every TICK_DIV enabled cycles.
module bird_tick_gen #(parameter int TICK_DIV = 2097152) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt;
  assign tick = en & (cnt == LAST);
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/bird_physics.sv
// bird_physics: bird vertical motion with gravity, flap impulses, ceiling clamp and floor death.
module bird_physics
  import bird_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int BIRD_SIZE = DEF_BIRD_SIZE,
  parameter int START_X   = DEF_START_X,
  parameter int START_Y   = DEF_START_Y,
  parameter int SCREEN_H  = SCREEN_ROWS,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int GRAVITY   = DEF_GRAVITY,
  parameter int FLAP_VEL  = DEF_FLAP_VEL,
  parameter int VMAX      = DEF_VMAX,
  parameter int VW        = DEF_VW
) (
  input logic clk,
  input logic reset,
  bird_physics_if.slave bus
);
  localparam int H = BIRD_SIZE / 2;
  localparam int SW = N + 2;
  localparam logic [N-1:0] SPAWN = N'(START_Y - H);
  localparam logic [N-1:0] FLOOR_TOP = N'(SCREEN_H - 1 - 2 * H);
  localparam logic signed [SW-1:0] FLOOR_T = SW'(SCREEN_H - 1 - 2 * H);
  localparam logic signed [VW-1:0] V_FLAP = VW'(-FLAP_VEL);
  localparam logic signed [VW-1:0] V_MAX = VW'(VMAX);
  localparam logic signed [VW-1:0] V_G = VW'(GRAVITY);
  bird_state_t st, st_n;
  logic [N-1:0] top, top_n;
  logic signed [VW-1:0] v, v_n, vg, vc;
  logic signed [SW-1:0] vx, t;
  logic flap_q, fe, tick;
  assign fe = bus.flap & ~flap_q;
  bird_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .en(st == FLY),
    .clr(st == DEAD ? bus.start : fe),
    .tick(tick)
  );
  // candidate top row in a width that can go negative or past the floor without wrapping
  assign vx = v;
  assign t = $signed({2'b00, top}) + vx;
  assign vg = v + V_G;
  assign vc = vg > V_MAX ? V_MAX : vg;
  always_comb begin
    st_n = st;
    top_n = top;
    v_n = v;
    unique case (st)
      IDLE: begin
        st_n = fe ? FLY : IDLE;
        v_n = fe ? V_FLAP : v;
      end
      FLY: begin
        if (bus.hit) st_n = DEAD;
        else if (fe) v_n = V_FLAP;
        else if (tick) begin
          v_n = t[SW-1] ? '0 : vc;
          top_n = t[SW-1] ? '0 : t >= FLOOR_T ? FLOOR_TOP : t[N-1:0];
          st_n = t >= FLOOR_T ? DEAD : FLY;
        end
      end
      DEAD: begin
        st_n = bus.start ? IDLE : DEAD;
        top_n = bus.start ? SPAWN : top;
        v_n = bus.start ? '0 : v;
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      top <= SPAWN;
      v <= '0;
      flap_q <= 1'b0;
    end else begin
      st <= st_n;
      top <= top_n;
      v <= v_n;
      flap_q <= bus.flap;
    end
  assign bus.x0 = N'(START_X);
  assign bus.x1 = N'(START_X);
  assign bus.y1 = top;
  assign bus.y0 = top + N'(2 * H);
  assign bus.vel = v;
  assign bus.state = st;
  assign bus.tick = tick;
endmodule

// File: tb/tb_bird_physics.sv
// tb_bird_physics: directed scenarios checked each cycle against an integer physics model.
module tb_bird_physics;
  localparam int TD = 4;
  localparam int H = 7;
  localparam int SPAWN = 233;
  typedef struct packed {int st; int top; int v; int cnt; bit fq;} model_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  bird_physics_if #(.N(10), .VW(6)) bus ();
  bird_physics #(.TICK_DIV(TD)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int nt = 0;
  int vmax_seen = -100;
  bit chk_on = 1'b0;
  model_t m;
  logic etk;
  function automatic model_t step(model_t c, bit rs, bit s, bit f, bit h);
    model_t n;
    bit fe;
    bit tk;
    int t;
    n = c;
    fe = f && !c.fq;
    tk = c.st == 1 && c.cnt == TD - 1;
    if (rs) begin
      n.st = 0; n.top = SPAWN; n.v = 0; n.cnt = 0; n.fq = 0;
      return n;
    end
    n.fq = f;
    if (c.st == 0 && fe) begin
      n.st = 1; n.v = -8; n.cnt = 0;
    end else if (c.st == 1) begin
      n.cnt = fe ? 0 : (c.cnt + 1) % TD;
      if (h) n.st = 2;
      else if (fe) n.v = -8;
      else if (tk) begin
        t = c.top + c.v;
        n.v = (c.v + 1 > 12) ? 12 : c.v + 1;
        if (t < 0) begin
          n.top = 0; n.v = 0;
        end else if (t + 2 * H >= 479) begin
          n.top = 479 - 2 * H; n.st = 2;
        end else n.top = t;
      end
    end else if (c.st == 2 && s) begin
      n.st = 0; n.top = SPAWN; n.v = 0; n.cnt = 0;
    end
    return n;
  endfunction
  always @(posedge clk) m <= step(m, reset, bus.start, bus.flap, bus.hit);
  assign etk = (m.st == 1 && m.cnt == TD - 1);
  always @(negedge clk) if (chk_on) begin
    tests++;
    if (bus.state !== 2'(m.st) || bus.y1 !== 10'(m.top) || bus.y0 !== 10'(m.top + 2 * H) ||
        $signed(bus.vel) != m.v || bus.tick !== etk || bus.x0 !== 10'd160 || bus.x1 !== 10'd160) begin
      fails++;
      $display("FAIL cycle @%0t: state=%0d/%0d y1=%0d/%0d y0=%0d/%0d vel=%0d/%0d tick=%0b/%0b x0=%0d x1=%0d (got/expected)",
               $time, bus.state, m.st, bus.y1, m.top, bus.y0, m.top + 2 * H,
               $signed(bus.vel), m.v, bus.tick, etk, bus.x0, bus.x1);
    end
    if (bus.tick) nt++;
    if ($signed(bus.vel) > vmax_seen) vmax_seen = $signed(bus.vel);
  end
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic wait_tick(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.tick && k < 40);
    if (!bus.tick) chk({name, "_tick_timeout"}, 0, 1);
  endtask
  task automatic after_tick(input string name);
    wait_tick(name);
    @(negedge clk);
  endtask
  initial begin
    @(posedge clk);
    #1 chk_on = 1'b1;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    int nt0;
    bus.start = 0; bus.flap = 0; bus.hit = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_state", bus.state, 0);
    chk("rst_y1", bus.y1, 233);
    chk("rst_y0", bus.y0, 247);
    chk("rst_vel", $signed(bus.vel), 0);
    nt0 = nt;
    repeat (25) @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (24) @(negedge clk);
    chk("idle_ticks", nt - nt0, 0);
    chk("idle_state", bus.state, 0);
    chk("idle_y1", bus.y1, 233);
    bus.flap = 1;
    @(negedge clk);
    chk("fly_state", bus.state, 1);
    chk("fly_vel", $signed(bus.vel), -8);
    chk("fly_y1", bus.y1, 233);
    after_tick("t1");
    chk("t1_y1", bus.y1, 225);
    chk("t1_vel", $signed(bus.vel), -7);
    after_tick("t2");
    chk("t2_y1", bus.y1, 218);
    chk("t2_vel", $signed(bus.vel), -6);
    after_tick("t3");
    chk("held_y1", bus.y1, 212);
    chk("held_vel", $signed(bus.vel), -5);
    repeat (8) @(negedge clk);
    bus.flap = 0;
    n = 0;
    while (bus.state != 2 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("floor_state", bus.state, 2);
    chk("floor_y0", bus.y0, 479);
    chk("floor_y1", bus.y1, 465);
    chk("floor_vel", $signed(bus.vel), 12);
    chk("vel_sat", vmax_seen, 12);
    for (int i = 0; i < 20; i++) begin
      bus.flap = i[0];
      bus.hit = 1;
      @(negedge clk);
    end
    bus.flap = 0; bus.hit = 0;
    chk("dead_y1", bus.y1, 465);
    chk("dead_state", bus.state, 2);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    chk("respawn_state", bus.state, 0);
    chk("respawn_y1", bus.y1, 233);
    chk("respawn_y0", bus.y0, 247);
    chk("respawn_vel", $signed(bus.vel), 0);
    n = 0;
    while (bus.y1 != 0 && n < 40) begin
      bus.flap = 1;
      @(negedge clk);
      bus.flap = 0;
      after_tick("ceil");
      n++;
    end
    chk("ceil_flaps", n, 30);
    chk("ceil_y1", bus.y1, 0);
    chk("ceil_y0", bus.y0, 14);
    chk("ceil_vel", $signed(bus.vel), 0);
    chk("ceil_state", bus.state, 1);
    wait_tick("ft");
    bus.flap = 1;
    @(negedge clk);
    bus.flap = 0;
    chk("ft_vel", $signed(bus.vel), -8);
    chk("ft_y1", bus.y1, 0);
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tick && n < 20);
    chk("ft_gap", n, 4);
    bus.hit = 1; bus.flap = 1;
    @(negedge clk);
    bus.hit = 0; bus.flap = 0;
    chk("hit_state", bus.state, 2);
    chk("hit_y1", bus.y1, 0);
    chk("hit_vel", $signed(bus.vel), -8);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    bus.flap = 1;
    @(negedge clk);
    bus.flap = 0;
    wait_tick("rt");
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rreset_state", bus.state, 0);
    chk("rreset_y1", bus.y1, 233);
    chk("rreset_vel", $signed(bus.vel), 0);
    chk("rreset_tick", bus.tick, 0);
    bus.flap = 1;
    @(negedge clk);
    bus.flap = 0;
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tick && n < 20);
    chk("rreset_gap", n, 4);
    @(negedge clk);
    chk("rreset_t1_y1", bus.y1, 225);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bird_physics.md
Name: bird_physics

Overview:
Parametrised bird motion engine for the Flappy Bird datapath, the successor to the simple flap/fall bird block. It adds a signed velocity register with constant gravity, terminal-velocity saturation, edge-detected flap impulses, and a configurable physics tick. It also adds explicit screen bounds and an IDLE/FLY/DEAD life-cycle. It feeds bounding-box coordinates to the renderer and pipe-collision logic, and takes a collision flag back from them.

Parameters:
N, 10, coordinate width in bits
BIRD_SIZE, 15, bird height in pixels; must be odd; H = BIRD_SIZE/2 = 7
START_X, 160, fixed horizontal position
START_Y, 240, spawn centre row
SCREEN_H, 480, screen height; valid rows are 0..SCREEN_H-1
TICK_DIV, 2097152, clk cycles per physics tick; minimum 2
GRAVITY, 1, velocity increment per tick, in px/tick
FLAP_VEL, 8, upward speed loaded on a flap, in px/tick
VMAX, 12, terminal downward speed, in px/tick
VW, 6, signed velocity width; must hold -FLAP_VEL..VMAX+GRAVITY

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; in DEAD it respawns the bird
flap  in  1  level input (key); only its rising edge acts
hit  in  1  pipe collision flag from the collision logic
x0  out  N  left/right x; equals START_X
x1  out  N  equals START_X
y0  out  N  bottom row = top + 2H
y1  out  N  top row
vel  out  VW  signed velocity; negative means upward
state  out  2  0=IDLE, 1=FLY, 2=DEAD
tick  out  1  one-cycle physics tick strobe, for debug and scoring

Behaviour:
- Reset, synchronous, with priority over everything:
  - state=IDLE, y1=START_Y-H, y0=START_Y+H, vel=0
  - tick counter=0, flap edge register=0, tick=0
- Flap edge: fe = flap & ~flap_q, where flap_q is registered every cycle including in DEAD. Holding flap gives exactly one impulse.
- Tick generator: runs only in FLY. It counts 0..TICK_DIV-1, and tick=1 in the cycle the count equals TICK_DIV-1; the count then wraps to 0. Any fe clears the count to 0.
- IDLE:
  - Position frozen, vel=0.
  - fe -> FLY next cycle with vel=-FLAP_VEL and position unchanged.
  - start is ignored.
- FLY, per-cycle priority is hit > fe > tick:
  - hit: go to DEAD; position and vel frozen.
  - fe: vel <= -FLAP_VEL; tick counter cleared; no move this cycle.
  - tick:
    - Compute t = y1 + vel in N+2-bit signed arithmetic.
    - vel <= min(vel + GRAVITY, VMAX), computed before the clamp.
    - If t < 0: y1 <= 0, y0 <= 2H, vel <= 0. The top is a ceiling, not a death.
    - Else if t + 2H >= SCREEN_H-1: y0 <= SCREEN_H-1, y1 <= SCREEN_H-1-2H, then go to DEAD.
    - Else: y1 <= t, y0 <= t + 2H.
  - Coordinates never wrap.
- DEAD:
  - Position, vel and tick counter frozen; tick=0; flap and hit ignored.
  - start -> IDLE with the reset spawn values; the counter is cleared.
- Invariants: y0 - y1 == 2H always; x0 == x1 == START_X always.

Decomposition:
- Package bird_pkg holds:
  - typedef enum logic [1:0] bird_state_t {IDLE, FLY, DEAD}
  - default physics constants
  - a screen-geometry localparam shared with the pipes and renderer
- One sub-module, bird_tick_gen (params TICK_DIV; ports clk, reset, en, clr, tick), is instantiated with en = (state==FLY) and clr = fe.

Test Plan (TICK_DIV=4, other parameters at default):
1. Reset, then 50 idle cycles -> state=0, y1=233, y0=247, vel=0, tick never asserted; start in IDLE has no effect.
2. Flap rising edge in IDLE -> state=1, vel=-8 next cycle. First tick at +4 cycles gives y1=225, vel=-7; second tick gives y1=218, vel=-6. Flap held high for 20 cycles yields no second impulse.
3. Free fall from y1=233 with vel=0 -> vel steps 1..12 and then stays at 12 (saturation). y1 rises by the cumulative velocity each tick. Reaching y0>=479 gives y0=479, y1=465, state=2, and the outputs then stay frozen for 20 cycles.
4. A flap edge on every tick from spawn -> y1 decreases to the ceiling, clamps at y1=0, y0=14, vel=0 on the clamping tick, and never wraps to a large value. State stays FLY.
5. hit and a flap edge in the same FLY cycle -> state=2, with y1 and vel equal to their pre-cycle values. A flap edge and a tick in the same cycle -> vel=-8, no position change, and the next tick occurs 4 cycles later.
6. In DEAD, pulse start -> state=0, y1=233, y0=247, vel=0. Assert reset mid-FLY during a tick cycle -> the spawn values appear next cycle and the tick count restarts from 0.
